// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and the axis-total helper,
// used by the timing generator and by pattern generators.
package vga_pkg;

  typedef logic [9:0] pos_t;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  function automatic int axis_total(input int display, input int front,
                                    input int sync, input int back);
    return display + front + sync + back;
  endfunction

  localparam int H_TOTAL = axis_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL = axis_total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus registered sync window.
// Visibility is exported as a next-state term so the top can register it together with the other axis.
module vga_axis_counter import vga_pkg::*; #(
  parameter int DISPLAY         = H_DISPLAY_DEF,
  parameter int FRONT           = H_FRONT_DEF,
  parameter int SYNC            = H_SYNC_DEF,
  parameter int BACK            = H_BACK_DEF,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [9:0] count,
  output logic       sync,
  output logic       visible_d,
  output logic       wrap
);

  localparam pos_t LAST       = pos_t'(axis_total(DISPLAY, FRONT, SYNC, BACK) - 1);
  localparam pos_t VIS_END    = pos_t'(DISPLAY);
  localparam pos_t SYNC_FIRST = pos_t'(DISPLAY + FRONT);
  localparam pos_t SYNC_LAST  = pos_t'(DISPLAY + FRONT + SYNC - 1);

  pos_t count_q, count_d;
  logic sync_q, sync_d;

  always_comb begin
    wrap    = advance && (count_q == LAST);
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (advance) begin
      count_d = count_q + 10'd1;
    end
    // Both compares look at the next position so they line up with count_q after the edge.
    visible_d = (count_d < VIS_END);
    sync_d    = ((count_d >= SYNC_FIRST) && (count_d <= SYNC_LAST)) ? ~SYNC_ACTIVE_LOW
                                                                     : SYNC_ACTIVE_LOW;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      sync_q  <= SYNC_ACTIVE_LOW;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal and vertical axis counters plus
// registered visibility, line/frame strobes and a frame counter.
module vga_timing_gen import vga_pkg::*; #(
  parameter int H_DISPLAY       = H_DISPLAY_DEF,
  parameter int H_FRONT         = H_FRONT_DEF,
  parameter int H_SYNC          = H_SYNC_DEF,
  parameter int H_BACK          = H_BACK_DEF,
  parameter int V_DISPLAY       = V_DISPLAY_DEF,
  parameter int V_FRONT         = V_FRONT_DEF,
  parameter int V_SYNC          = V_SYNC_DEF,
  parameter int V_BACK          = V_BACK_DEF,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] frame_count
);

  logic h_wrap, v_wrap;
  logic h_visible_d, v_visible_d;

  vga_axis_counter #(
    .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
  ) u_h_axis (
    .clk(clk), .reset(reset), .advance(ce),
    .count(hpos), .sync(hsync), .visible_d(h_visible_d), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
  ) u_v_axis (
    .clk(clk), .reset(reset), .advance(h_wrap),
    .count(vpos), .sync(vsync), .visible_d(v_visible_d), .wrap(v_wrap)
  );

  logic       display_on_q, display_on_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  pos_t       frame_count_q, frame_count_d;

  // Strobes are driven from the wrap itself, so they drop on the next edge even if ce stays low.
  always_comb begin
    display_on_d  = h_visible_d && v_visible_d;
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
    frame_count_d = v_wrap ? frame_count_q + 10'd1 : frame_count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      display_on_q  <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign display_on  = display_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 16x10 raster (8x6 visible),
// so full frames fit in a short run; sync windows hpos 10..12 and vpos 7..8.
module tb_vga_timing_gen;

  localparam int FT = 160;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic [9:0] hpos, vpos, frame_count;
  logic       display_on, hsync, vsync, line_start, frame_start;

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hpos"}, 32'(hpos), 0);
    check({tag, "_vpos"}, 32'(vpos), 0);
    check({tag, "_frame_count"}, 32'(frame_count), 0);
    check({tag, "_display_on"}, 32'(display_on), 1);
    check({tag, "_hsync"}, 32'(hsync), 1);
    check({tag, "_vsync"}, 32'(vsync), 1);
    check({tag, "_line_start"}, 32'(line_start), 0);
    check({tag, "_frame_start"}, 32'(frame_start), 0);
  endtask

  int   ls_cnt, fs_cnt, first_ls, prev_ls_i, gap_min, gap_max, prev_fs_i, fs_gap;
  int   hs_low, hs_min, hs_max, vs_low, vs_min, vs_max;
  int   disp_cnt, disp_line6, disp_hmax, disp_vmax, ls_bad, fs_bad, n;
  logic prev_ls;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_reset_values("rst");

    // Two frames with ce held high
    reset = 1'b0;
    ce = 1'b1;
    ls_cnt = 0; fs_cnt = 0; first_ls = -1; prev_ls_i = -1; gap_min = 9999; gap_max = -1;
    prev_fs_i = -1; fs_gap = -1; hs_low = 0; hs_min = 9999; hs_max = -1;
    vs_low = 0; vs_min = 9999; vs_max = -1; disp_cnt = 0; disp_line6 = 0;
    disp_hmax = -1; disp_vmax = -1; ls_bad = 0; fs_bad = 0; prev_ls = 1'b0;
    for (int i = 0; i < 2 * FT; i++) begin
      @(negedge clk);
      if (line_start) begin
        ls_cnt++;
        if (first_ls < 0) first_ls = i;
        if (prev_ls_i >= 0) begin
          if (i - prev_ls_i < gap_min) gap_min = i - prev_ls_i;
          if (i - prev_ls_i > gap_max) gap_max = i - prev_ls_i;
        end
        prev_ls_i = i;
        if (prev_ls || hpos != 10'd0) ls_bad++;
      end
      if (frame_start) begin
        fs_cnt++;
        if (prev_fs_i >= 0) fs_gap = i - prev_fs_i;
        prev_fs_i = i;
        if (!(line_start && hpos == 10'd0 && vpos == 10'd0)) fs_bad++;
      end
      if (!hsync) begin
        hs_low++;
        if (int'(hpos) < hs_min) hs_min = int'(hpos);
        if (int'(hpos) > hs_max) hs_max = int'(hpos);
      end
      if (!vsync) begin
        vs_low++;
        if (int'(vpos) < vs_min) vs_min = int'(vpos);
        if (int'(vpos) > vs_max) vs_max = int'(vpos);
      end
      if (display_on) begin
        disp_cnt++;
        if (int'(hpos) > disp_hmax) disp_hmax = int'(hpos);
        if (int'(vpos) > disp_vmax) disp_vmax = int'(vpos);
        if (vpos == 10'd6) disp_line6++;
      end
      prev_ls = line_start;
    end
    check("run_line_start_count", 32'(ls_cnt), 20);
    check("run_first_line_start", 32'(first_ls), 15);
    check("run_hpos_period_min", 32'(gap_min), 16);
    check("run_hpos_period_max", 32'(gap_max), 16);
    check("run_frame_start_count", 32'(fs_cnt), 2);
    check("run_frame_period", 32'(fs_gap), FT);
    check("run_frame_count", 32'(frame_count), 2);
    check("run_line_start_shape", 32'(ls_bad), 0);
    check("run_frame_start_shape", 32'(fs_bad), 0);
    check("hsync_low_cycles", 32'(hs_low), 60);
    check("hsync_first_hpos", 32'(hs_min), 10);
    check("hsync_last_hpos", 32'(hs_max), 12);
    check("vsync_low_cycles", 32'(vs_low), 64);
    check("vsync_first_vpos", 32'(vs_min), 7);
    check("vsync_last_vpos", 32'(vs_max), 8);
    check("display_on_cycles", 32'(disp_cnt), 96);
    check("display_on_last_hpos", 32'(disp_hmax), 7);
    check("display_on_last_vpos", 32'(disp_vmax), 5);
    check("display_on_line6", 32'(disp_line6), 0);

    // Boundary at the last position of the frame
    repeat (FT - 1) @(negedge clk);
    check("edge_hpos", 32'(hpos), 15);
    check("edge_vpos", 32'(vpos), 9);
    check("edge_vsync", 32'(vsync), 1);
    check("edge_line_start", 32'(line_start), 0);
    @(negedge clk);
    check("wrap_hpos", 32'(hpos), 0);
    check("wrap_vpos", 32'(vpos), 0);
    check("wrap_line_start", 32'(line_start), 1);
    check("wrap_frame_start", 32'(frame_start), 1);
    check("wrap_vsync", 32'(vsync), 1);
    check("wrap_display_on", 32'(display_on), 1);
    check("wrap_frame_count", 32'(frame_count), 3);

    // ce asserted one cycle in four
    ls_cnt = 0; prev_ls_i = -1; gap_min = 9999; gap_max = -1; ls_bad = 0; prev_ls = 1'b0;
    for (int k = 0; k < 200; k++) begin
      ce = (k % 4 == 0);
      @(negedge clk);
      if (line_start) begin
        ls_cnt++;
        if (prev_ls_i >= 0) begin
          if (k - prev_ls_i < gap_min) gap_min = k - prev_ls_i;
          if (k - prev_ls_i > gap_max) gap_max = k - prev_ls_i;
        end
        prev_ls_i = k;
        if (prev_ls) ls_bad++;
      end
      prev_ls = line_start;
    end
    check("slow_line_start_count", 32'(ls_cnt), 3);
    check("slow_hpos_period_min", 32'(gap_min), 64);
    check("slow_hpos_period_max", 32'(gap_max), 64);
    check("slow_line_start_width", 32'(ls_bad), 0);
    check("slow_end_hpos", 32'(hpos), 2);
    check("slow_end_vpos", 32'(vpos), 3);

    // Asynchronous reset inside both sync windows
    ce = 1'b1;
    repeat (73) @(negedge clk);
    check("pre_rst_hpos", 32'(hpos), 11);
    check("pre_rst_vpos", 32'(vpos), 7);
    check("pre_rst_hsync", 32'(hsync), 0);
    check("pre_rst_vsync", 32'(vsync), 0);
    check("pre_rst_display_on", 32'(display_on), 0);
    #2 reset = 1'b1;
    #1 check_reset_values("async_rst");
    @(negedge clk);
    reset = 1'b0;
    n = 0; first_ls = 0;
    while (n < 3 * FT) begin
      @(negedge clk);
      n++;
      if (line_start && first_ls == 0) first_ls = n;
      if (frame_start) break;
    end
    check("post_rst_frame_start_delay", 32'(n), FT);
    check("post_rst_first_line_start", 32'(first_ls), 16);
    check("post_rst_frame_count", 32'(frame_count), 1);

    // frame_count wrap from a forced 1023
    ce = 1'b0;
    force dut.frame_count_q = 10'd1023;
    @(negedge clk);
    release dut.frame_count_q;
    @(negedge clk);
    check("preload_frame_count", 32'(frame_count), 1023);
    check("hold_hpos", 32'(hpos), 0);
    check("hold_line_start_cleared", 32'(line_start), 0);
    check("hold_frame_start_cleared", 32'(frame_start), 0);
    ce = 1'b1;
    n = 0;
    while (n < 3 * FT) begin
      @(negedge clk);
      n++;
      if (frame_start) break;
    end
    check("wrap1023_delay", 32'(n), FT);
    check("wrap1023_frame_count", 32'(frame_count), 0);
    check("wrap1023_line_start", 32'(line_start), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
